ring_injector: RTL and testbench
================================

# ring_injector

Transmit-side companion to the ring node. Sits between one short-range force PE and its local ring node. It accepts per-pair partial forces tagged with destination cell and particle ID, and buffers them in a small FIFO. It forms `packet_t` packets and injects them into the ring under the node's `pe_ready` flow control. It also filters all-zero forces and reports batch completion back to the PE controller.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of one force component
- `PARTICLE_ID_WIDTH`, 7, particle ID width
- `NODE_ID_WIDTH`, 6, cell/node ID width (log2 NUM_CELLS)
- `FORCE_CACHE_WIDTH`, 3*DATA_WIDTH, force vector {fz,fy,fx}
- `FORCE_DATA_WIDTH`, FORCE_CACHE_WIDTH+PARTICLE_ID_WIDTH, payload width
- `PACKET_WIDTH`, FORCE_DATA_WIDTH+NODE_ID_WIDTH, packet width
- `FIFO_DEPTH`, 8, entries; power of two, ≥2
- `DROP_ZERO`, 1, 1 = discard packets whose force vector is all zero

Ports:
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `pe_force_in`  in  FORCE_CACHE_WIDTH  force vector from PE
- `pe_pid_in`  in  PARTICLE_ID_WIDTH  target particle ID
- `pe_dest_in`  in  NODE_ID_WIDTH  destination cell ID
- `pe_last_in`  in  1  marks final force of current batch
- `pe_force_valid`  in  1  input beat valid
- `in_ready`  out  1  input beat may be accepted
- `pkt_out`  out  packet_t  to ring node `pe_pkt_in`
- `pkt_valid`  out  1  to ring node `pe_pkt_valid`
- `pkt_ready`  in  1  from ring node `pe_ready`
- `batch_busy`  out  1  batch in progress
- `batch_done`  out  1  one-cycle pulse, batch fully injected
- `pkt_count`  out  16  packets injected since reset, wraps
- `overflow`  out  1  sticky: valid asserted while `in_ready` low

## Operation
- Input accept: `pe_force_valid & in_ready`. `in_ready = (count != FIFO_DEPTH)`, from registered count only.
  - A push is refused when the FIFO is full, even if a pop happens in the same cycle.
- Entry stored: {marker, last, packet}.
  - `packet.dest_id = pe_dest_in`.
  - `packet.payload = {pe_pid_in, pe_force_in}`.
- Zero filter (`DROP_ZERO=1`, force == 0):
  - last=0: beat accepted and discarded, nothing stored.
  - last=1: stored as a marker entry (marker=1).
- Output is first-word-fall-through:
  - `pkt_valid = ~empty & ~head.marker`.
  - `pkt_out = head.packet`, or 0 when `pkt_valid` is low.
- Pop:
  - Normal entry: `pkt_valid & pkt_ready`.
  - Marker entry: popped automatically in the cycle it is at the head, without asserting `pkt_valid`.
- `pkt_count` increments on each normal pop.
- Batch FSM, IDLE → ACTIVE → IDLE:
  - IDLE → ACTIVE on any accepted beat.
  - ACTIVE → IDLE on popping an entry with last=1, normal or marker. That same pop registers `batch_done`=1 for one cycle.
  - `batch_busy` = (state == ACTIVE).
  - An accepted beat in the same cycle as the done pop keeps the FSM in ACTIVE.
  - A single-beat batch (accept with last=1 in IDLE) enters ACTIVE.
- `overflow` sets when `pe_force_valid & ~in_ready` and clears only on reset.
- Reset values (applied asynchronously, all outputs):
  - `in_ready`=1 (count=0)
  - `pkt_valid`=0, `pkt_out`=0
  - `batch_busy`=0, `batch_done`=0
  - `pkt_count`=0, `overflow`=0
  - FIFO pointers cleared
  - Reset mid-batch discards all buffered entries, with no `batch_done`.

## Timing
- Push at edge N into empty FIFO → `pkt_valid` high after edge N (visible cycle N+1). Zero-cycle combinational bypass is forbidden.
- `pkt_out`/`pkt_valid` hold stable until popped.
- The ring node drops `pe_ready` one cycle after a collision capture. The injector relies only on `pkt_valid & pkt_ready` at the edge.
- Back-to-back pops sustain 1 packet/cycle.
- Marker at head is consumed in 1 cycle. `batch_done` is asserted the cycle after the pop edge.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged.
- Pointers wrap modulo FIFO_DEPTH. Count is $clog2(FIFO_DEPTH)+1 bits.

## Structure
- Add to `md_pkg`: `inj_entry_t` (marker, last, `packet_t`). `packet_t` and `force_data_t` are already there.
- Sub-module `md_sync_fifo` (parameterized width/depth, FWFT, count output, async active-high reset). It is reusable for force cache input buffering.
- The FSM, zero filter, marker pop and counters live in `ring_injector`.

## Test plan
- Single beat: force {3,2,1}, pid 5, dest 9, last=1 → next cycle `pkt_valid`=1, `pkt_out`={9,{5,3,2,1}}. With `pkt_ready`=1, one cycle later `batch_done` pulses and `pkt_count`=1.
- Backpressure: push 10 beats with `pkt_ready`=0, DEPTH=8 →
  - `in_ready`=0 after 8 accepts; `overflow`=1.
  - Raising `pkt_ready` drains 8 packets in order at 1/cycle.
- Zero filter: beats zero/last=0, nonzero/last=0, zero/last=1 → exactly 1 packet out, then `batch_done` 1 cycle after the marker is popped. `pkt_count`=1.
- Ring-node stall emulation: toggle `pkt_ready` pattern 1,0,0,1 → no packet lost or duplicated, `pkt_out` stable while `pkt_ready`=0.
- Reset mid-batch: 4 entries buffered, `batch_busy`=1, assert `rst` asynchronously →
  - All outputs at reset values immediately.
  - No `batch_done`.
  - `pkt_count`=0.
- Full with simultaneous pop: count=8, `pe_force_valid`=1 and pop in the same cycle → push refused, count=7, `in_ready`=1 the next cycle.

Source files
------------

// File: rtl/md_pkg.sv
// Shared types for the MD ring fabric: force payloads, ring packets and injector FIFO entries.
package md_pkg;

  localparam int unsigned MD_DATA_WIDTH        = 32;
  localparam int unsigned MD_PARTICLE_ID_WIDTH = 7;
  localparam int unsigned MD_NODE_ID_WIDTH     = 6;
  localparam int unsigned MD_FORCE_CACHE_WIDTH = 3 * MD_DATA_WIDTH;

  // Force vector packed as {fz, fy, fx}.
  typedef struct packed {
    logic [MD_PARTICLE_ID_WIDTH-1:0] pid;
    logic [MD_FORCE_CACHE_WIDTH-1:0] force_vec;
  } force_data_t;

  typedef struct packed {
    logic [MD_NODE_ID_WIDTH-1:0] dest_id;
    force_data_t                 payload;
  } packet_t;

  // A marker entry carries only the batch-end flag; it is never presented to the ring.
  typedef struct packed {
    logic    marker;
    logic    last;
    packet_t packet;
  } inj_entry_t;

  localparam int unsigned MD_FORCE_DATA_WIDTH = $bits(force_data_t);
  localparam int unsigned MD_PACKET_WIDTH     = $bits(packet_t);
  localparam int unsigned MD_INJ_ENTRY_WIDTH  = $bits(inj_entry_t);

  typedef enum logic {
    StIdle,
    StActive
  } batch_state_e;

endpackage

// File: rtl/md_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and async active-high reset.
module md_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             do_wr;
  logic             do_rd;

  // Full refuses a write even when a read frees a slot in the same cycle.
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
    if (do_rd) rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
    unique case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/ring_injector.sv
// Transmit-side injector: buffers PE force beats, filters zero forces, injects packets into the
// ring node under pe_ready flow control and reports batch completion.
module ring_injector
  import md_pkg::*;
#(
  parameter int unsigned DATA_WIDTH        = MD_DATA_WIDTH,
  parameter int unsigned PARTICLE_ID_WIDTH = MD_PARTICLE_ID_WIDTH,
  parameter int unsigned NODE_ID_WIDTH     = MD_NODE_ID_WIDTH,
  parameter int unsigned FORCE_CACHE_WIDTH = 3 * DATA_WIDTH,
  parameter int unsigned FORCE_DATA_WIDTH  = FORCE_CACHE_WIDTH + PARTICLE_ID_WIDTH,
  parameter int unsigned PACKET_WIDTH      = FORCE_DATA_WIDTH + NODE_ID_WIDTH,
  parameter int unsigned FIFO_DEPTH        = 8,
  parameter bit          DROP_ZERO         = 1'b1,
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [FORCE_CACHE_WIDTH-1:0] pe_force_in,
  input  logic [PARTICLE_ID_WIDTH-1:0] pe_pid_in,
  input  logic [NODE_ID_WIDTH-1:0]     pe_dest_in,
  input  logic                         pe_last_in,
  input  logic                         pe_force_valid,
  output logic                         in_ready,
  output packet_t                      pkt_out,
  output logic                         pkt_valid,
  input  logic                         pkt_ready,
  output logic                         batch_busy,
  output logic                         batch_done,
  output logic [15:0]                  pkt_count,
  output logic                         overflow
);

  logic [FORCE_DATA_WIDTH-1:0] payload_bits;
  logic [PACKET_WIDTH-1:0]     packet_bits;
  inj_entry_t                  wr_entry;
  inj_entry_t                  head;
  logic [MD_INJ_ENTRY_WIDTH-1:0] head_bits;
  logic                        fifo_empty;
  logic [CNT_W-1:0]            fifo_count;

  logic accept;
  logic is_zero;
  logic push;
  logic normal_pop;
  logic marker_pop;
  logic pop;
  logic done_pop;

  batch_state_e state_q, state_d;
  logic         batch_done_q;
  logic [15:0]  pkt_count_q;
  logic         overflow_q;

  assign in_ready = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign accept   = pe_force_valid & in_ready;
  assign is_zero  = DROP_ZERO && (pe_force_in == '0);
  // Zero forces vanish unless they close a batch; then only the last flag survives as a marker.
  assign push     = accept & ~(is_zero & ~pe_last_in);

  assign payload_bits     = {pe_pid_in, pe_force_in};
  assign packet_bits      = {pe_dest_in, payload_bits};
  assign wr_entry.marker  = is_zero;
  assign wr_entry.last    = pe_last_in;
  assign wr_entry.packet  = packet_bits;

  md_sync_fifo #(
    .WIDTH (MD_INJ_ENTRY_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_data (head_bits),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign head       = head_bits;
  assign pkt_valid  = ~fifo_empty & ~head.marker;
  assign pkt_out    = pkt_valid ? head.packet : '0;
  assign normal_pop = pkt_valid & pkt_ready;
  assign marker_pop = ~fifo_empty & head.marker;
  assign pop        = normal_pop | marker_pop;
  assign done_pop   = pop & head.last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StActive;
      StActive: if (done_pop && !accept) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    batch_busy = (state_q == StActive);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      batch_done_q <= 1'b0;
      pkt_count_q  <= '0;
      overflow_q   <= 1'b0;
    end else begin
      batch_done_q <= done_pop;
      if (normal_pop) pkt_count_q <= pkt_count_q + 16'd1;
      if (pe_force_valid && !in_ready) overflow_q <= 1'b1;
    end
  end

  assign batch_done = batch_done_q;
  assign pkt_count  = pkt_count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ring_injector.sv
// Scoreboard bench for ring_injector: directed beats queue expected packets, a negedge monitor
// checks every injected packet in order and that a stalled packet holds steady.
module tb_ring_injector;
  import md_pkg::*;

  logic          clk;
  logic          rst;
  logic [95:0]   pe_force_in;
  logic [6:0]    pe_pid_in;
  logic [5:0]    pe_dest_in;
  logic          pe_last_in;
  logic          pe_force_valid;
  logic          in_ready;
  packet_t       pkt_out;
  logic          pkt_valid;
  logic          pkt_ready;
  logic          batch_busy;
  logic          batch_done;
  logic [15:0]   pkt_count;
  logic          overflow;

  int            tests;
  int            fails;
  int            done_cnt;
  logic [108:0]  exp_q[$];
  logic          prev_stall;
  logic [108:0]  prev_pkt;

  ring_injector dut (
    .clk            (clk),
    .rst            (rst),
    .pe_force_in    (pe_force_in),
    .pe_pid_in      (pe_pid_in),
    .pe_dest_in     (pe_dest_in),
    .pe_last_in     (pe_last_in),
    .pe_force_valid (pe_force_valid),
    .in_ready       (in_ready),
    .pkt_out        (pkt_out),
    .pkt_valid      (pkt_valid),
    .pkt_ready      (pkt_ready),
    .batch_busy     (batch_busy),
    .batch_done     (batch_done),
    .pkt_count      (pkt_count),
    .overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 128'(pkt_valid), 128'd1);
        check("hold_pkt", 128'(pkt_out), 128'(prev_pkt));
      end
      if (pkt_valid && pkt_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_extra: got packet %0h, required none", pkt_out);
        end else begin
          check("sb_pkt", 128'(pkt_out), 128'(exp_q.pop_front()));
        end
      end
      prev_stall = pkt_valid & ~pkt_ready;
      prev_pkt   = pkt_out;
      if (batch_done) done_cnt++;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one beat at edge+1; acceptance is known from the registered in_ready.
  task automatic send(input logic [95:0] f, input logic [6:0] pid, input logic [5:0] dest,
                      input logic last, output logic acc);
    pe_force_in    = f;
    pe_pid_in      = pid;
    pe_dest_in     = dest;
    pe_last_in     = last;
    pe_force_valid = 1'b1;
    acc            = in_ready;
    @(posedge clk);
    #1;
    pe_force_valid = 1'b0;
    if (acc && f != 96'd0) exp_q.push_back({dest, pid, f});
  endtask

  initial begin
    logic acc;
    int   n_acc;
    int   d0;
    tests          = 0;
    fails          = 0;
    done_cnt       = 0;
    prev_stall     = 1'b0;
    prev_pkt       = '0;
    pe_force_in    = '0;
    pe_pid_in      = '0;
    pe_dest_in     = '0;
    pe_last_in     = 1'b0;
    pe_force_valid = 1'b0;
    pkt_ready      = 1'b0;

    // Reset state
    do_reset();
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_pkt_valid", 128'(pkt_valid), 128'd0);
    check("rst_pkt_out", 128'(pkt_out), 128'd0);
    check("rst_busy", 128'(batch_busy), 128'd0);
    check("rst_done", 128'(batch_done), 128'd0);
    check("rst_count", 128'(pkt_count), 128'd0);
    check("rst_overflow", 128'(overflow), 128'd0);

    // Single-beat batch
    pkt_ready = 1'b1;
    send({32'd3, 32'd2, 32'd1}, 7'd5, 6'd9, 1'b1, acc);
    check("t1_valid", 128'(pkt_valid), 128'd1);
    check("t1_pkt", 128'(pkt_out), {19'd0, 6'd9, 7'd5, 32'd3, 32'd2, 32'd1});
    check("t1_busy", 128'(batch_busy), 128'd1);
    cycles(1);
    check("t1_done", 128'(batch_done), 128'd1);
    check("t1_count", 128'(pkt_count), 128'd1);
    check("t1_idle", 128'(batch_busy), 128'd0);
    cycles(1);
    check("t1_done_pulse", 128'(batch_done), 128'd0);

    // Zero filter
    do_reset();
    pkt_ready = 1'b1;
    d0 = done_cnt;
    send(96'd0, 7'd1, 6'd2, 1'b0, acc);
    check("t3_zero_valid", 128'(pkt_valid), 128'd0);
    send({32'd0, 32'd0, 32'h77}, 7'd4, 6'd3, 1'b0, acc);
    check("t3_nz_valid", 128'(pkt_valid), 128'd1);
    send(96'd0, 7'd6, 6'd3, 1'b1, acc);
    check("t3_marker_hidden", 128'(pkt_valid), 128'd0);
    check("t3_no_early_done", 128'(batch_done), 128'd0);
    cycles(1);
    check("t3_done", 128'(batch_done), 128'd1);
    check("t3_count", 128'(pkt_count), 128'd1);
    cycles(2);
    check("t3_done_once", 128'(done_cnt - d0), 128'd1);

    // Ring-node stall emulation: ready 1,0,0,1
    do_reset();
    pkt_ready = 1'b0;
    d0 = done_cnt;
    send({32'd10, 32'd11, 32'd12}, 7'd20, 6'd1, 1'b0, acc);
    send({32'd13, 32'd14, 32'd15}, 7'd21, 6'd2, 1'b1, acc);
    pkt_ready = 1'b1; cycles(1);
    pkt_ready = 1'b0; cycles(1);
    cycles(1);
    pkt_ready = 1'b1; cycles(1);
    cycles(2);
    check("t4_count", 128'(pkt_count), 128'd2);
    check("t4_sb_empty", 128'(exp_q.size()), 128'd0);
    check("t4_done", 128'(done_cnt - d0), 128'd1);

    // Backpressure: 10 beats into depth 8
    do_reset();
    pkt_ready = 1'b0;
    d0 = done_cnt;
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      send({32'(i + 1), 32'(i + 100), 32'(i + 200)}, 7'(i), 6'(i + 30), (i == 7), acc);
      if (acc) n_acc++;
    end
    check("t2_accepted", 128'(n_acc), 128'd8);
    check("t2_in_ready", 128'(in_ready), 128'd0);
    check("t2_overflow", 128'(overflow), 128'd1);
    pkt_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t2_drain_rate", 128'(pkt_valid), 128'd1);
    end
    @(negedge clk);
    check("t2_drained", 128'(pkt_valid), 128'd0);
    cycles(2);
    check("t2_count", 128'(pkt_count), 128'd8);
    check("t2_sb_empty", 128'(exp_q.size()), 128'd0);
    check("t2_done", 128'(done_cnt - d0), 128'd1);

    // Full with simultaneous pop
    do_reset();
    pkt_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send({32'(i + 50), 32'd0, 32'd9}, 7'(i + 40), 6'(i), (i == 7), acc);
    end
    pkt_ready = 1'b1;
    send({32'd99, 32'd99, 32'd99}, 7'd99, 6'd9, 1'b0, acc);
    check("t6_refused", 128'(acc), 128'd0);
    check("t6_in_ready", 128'(in_ready), 128'd1);
    check("t6_count", 128'(pkt_count), 128'd1);
    cycles(10);
    check("t6_total", 128'(pkt_count), 128'd8);
    check("t6_sb_empty", 128'(exp_q.size()), 128'd0);

    // Reset mid-batch
    do_reset();
    pkt_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send({32'd1, 32'd2, 32'(i + 1)}, 7'(i), 6'd5, 1'b0, acc);
    end
    check("t5_busy", 128'(batch_busy), 128'd1);
    check("t5_valid", 128'(pkt_valid), 128'd1);
    d0 = done_cnt;
    #2;
    rst = 1'b1;
    #1;
    check("t5_in_ready", 128'(in_ready), 128'd1);
    check("t5_pkt_valid", 128'(pkt_valid), 128'd0);
    check("t5_pkt_out", 128'(pkt_out), 128'd0);
    check("t5_busy_clr", 128'(batch_busy), 128'd0);
    check("t5_done_clr", 128'(batch_done), 128'd0);
    check("t5_count_clr", 128'(pkt_count), 128'd0);
    check("t5_overflow_clr", 128'(overflow), 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    pkt_ready = 1'b1;
    cycles(4);
    check("t5_no_pkt", 128'(pkt_valid), 128'd0);
    check("t5_no_done", 128'(done_cnt - d0), 128'd0);
    check("t5_count_after", 128'(pkt_count), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
